// File: rtl/axi4_lite_slv_regs.sv
// AXI4-Lite responder with a bank of byte-strobed memory-mapped registers.
// Optional macro AXI4_LITE_SLV_PROT_CHECK_EN: unprivileged accesses (prot[0] = 0) are refused with SLVERR.
module axi4_lite_slv_regs #(
    parameter int                      P_DATA_WIDTH = 32,
    parameter int                      P_ADDR_WIDTH = 32,
    parameter int                      P_NUM_REGS   = 16,
    parameter logic [P_ADDR_WIDTH-1:0] P_BASE_ADDR  = '0,
    parameter logic [P_DATA_WIDTH-1:0] P_RESET_VAL  = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               awvalid,
    input  logic [P_ADDR_WIDTH-1:0]            awaddr,
    input  logic [2:0]                         awprot,
    output logic                               awready,
    input  logic                               wvalid,
    input  logic [P_DATA_WIDTH-1:0]            wdata,
    input  logic [P_DATA_WIDTH/8-1:0]          wstrb,
    output logic                               wready,
    input  logic                               bready,
    output logic                               bvalid,
    output logic [2:0]                         bresp,
    input  logic                               arvalid,
    input  logic [P_ADDR_WIDTH-1:0]            araddr,
    input  logic [2:0]                         arprot,
    output logic                               arready,
    input  logic                               rready,
    output logic                               rvalid,
    output logic [P_DATA_WIDTH-1:0]            rdata,
    output logic [2:0]                         rresp,
    output logic [P_NUM_REGS*P_DATA_WIDTH-1:0] regs_o
);

    localparam int STRB_W     = P_DATA_WIDTH / 8;
    localparam int LANE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1;
    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;

    // Handshake rule: a transfer happens on a rising edge where valid && ready;
    // a raised valid is held with its payload stable until that edge.

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    function automatic logic addr_hit(input logic [P_ADDR_WIDTH-1:0] a);
        logic [P_ADDR_WIDTH-1:0] offs;
        offs = a - P_BASE_ADDR;
        return (a >= P_BASE_ADDR) && ((offs >> LANE_SHIFT) < P_ADDR_WIDTH'(P_NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [P_ADDR_WIDTH-1:0] a);
        logic [P_ADDR_WIDTH-1:0] offs;
        offs = a - P_BASE_ADDR;
        return IDX_W'(offs >> LANE_SHIFT);
    endfunction

    logic [P_DATA_WIDTH-1:0] regs [P_NUM_REGS];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    // Ready outputs stay low until the first clock edge after reset is released.
    logic active;

    logic                    aw_held, w_held;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic [P_DATA_WIDTH-1:0] data_q;
    logic [STRB_W-1:0]       strb_q;

    logic                    aw_hs, w_hs, ar_hs, w_done;
    logic [P_ADDR_WIDTH-1:0] eff_addr;
    logic [P_DATA_WIDTH-1:0] eff_data;
    logic [STRB_W-1:0]       eff_strb;
    logic                    w_hit, r_hit;
    logic [IDX_W-1:0]        w_idx, r_idx;

    logic unused_prot;
    assign unused_prot = ^{awprot, arprot};

    assign awready = active && (w_state == W_IDLE) && !aw_held;
    assign wready  = active && (w_state == W_IDLE) && !w_held;
    assign bvalid  = (w_state == W_RESP);
    assign arready = active && (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // The access completes in the cycle the later of AW/W arrives, so use the live
    // channel payload when it is handshaking now and the latched copy otherwise.
    assign eff_addr = aw_held ? addr_q : awaddr;
    assign eff_data = w_held ? data_q : wdata;
    assign eff_strb = w_held ? strb_q : wstrb;
    assign w_done   = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign w_idx    = addr_idx(eff_addr);
    assign r_idx    = addr_idx(araddr);

`ifdef AXI4_LITE_SLV_PROT_CHECK_EN
    logic prot_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            prot_q <= 1'b0;
        end else if (aw_hs && !w_done) begin
            prot_q <= awprot[0];
        end
    end
    assign w_hit = addr_hit(eff_addr) && (aw_held ? prot_q : awprot[0]);
    assign r_hit = addr_hit(araddr) && arprot[0];
`else
    assign w_hit = addr_hit(eff_addr);
    assign r_hit = addr_hit(araddr);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            active  <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (w_done) w_next = W_RESP;
            W_RESP:  if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp   <= RESP_OKAY;
            for (int i = 0; i < P_NUM_REGS; i++) begin
                regs[i] <= P_RESET_VAL;
            end
        end else if (w_done) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp   <= w_hit ? RESP_OKAY : RESP_SLVERR;
            if (w_hit) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (eff_strb[b]) regs[w_idx][b*8 +: 8] <= eff_data[b*8 +: 8];
                end
            end
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                addr_q  <= awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                data_q <= wdata;
                strb_q <= wstrb;
            end
        end
    end

    // Sampling regs here with non-blocking semantics gives the pre-write value
    // when a write lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata <= r_hit ? regs[r_idx] : '0;
            rresp <= r_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    for (genvar g = 0; g < P_NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*P_DATA_WIDTH +: P_DATA_WIDTH] = regs[g];
    end

endmodule
